// File: rtl/pipe_pkg.sv
// Shared constants, opcodes and FSM state type for the pipeline stage controller.
// Imported by pipe_reg and pipe_stage_ctrl.
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP   = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD    = 7'b0000011;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic stage register: synchronous reset value, synchronous clear-to-value,
// and a hold enable. Clear wins over hold.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         clr,
    input  logic [W-1:0] clr_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // reset, then clear, then hold, else capture d
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= clr_val;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Fetch/MW/MW2 stage control with stall/flush handling and a hazard FSM.
// Optional PIPE_PERF_CNT_EN adds stall/flush/retire counters.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = PIPE_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        stall_MW,
    input  logic        flush,
    input  logic [31:0] br_target,
    input  logic [31:0] inst_F,
    input  logic [31:0] alu_res,
    input  logic        reg_wr,
    output logic [31:0] pc_F,
    output logic [31:0] inst_machine_codeMW,
    output logic [31:0] pc_MW,
    output logic [31:0] inst_machine_codeMW2,
    output logic [31:0] alu_resMW2,
    output logic        reg_wrMW2,
    output logic        valid_MW,
    output logic        valid_MW2,
    output logic [1:0]  ctrl_state,
    output logic        hz_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] retire_cnt
`endif
);

    // a flush arriving with a stall is dropped; the hazard unit re-issues it
    logic        acc_flush;
    ctrl_state_t state;

    assign acc_flush  = flush & ~stall;
    assign ctrl_state = state;

    // fetch PC
    pipe_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc_f (
        .clk(clk), .rst_n(rst_n), .hold(stall), .clr(acc_flush),
        .clr_val(br_target), .d(pc_F + 32'd4), .q(pc_F)
    );

    // MW stage
    pipe_reg #(.W(32), .RST_VAL(NOP_INST)) u_inst_mw (
        .clk(clk), .rst_n(rst_n), .hold(stall), .clr(acc_flush),
        .clr_val(NOP_INST), .d(inst_F), .q(inst_machine_codeMW)
    );

    pipe_reg #(.W(32), .RST_VAL(32'h0)) u_pc_mw (
        .clk(clk), .rst_n(rst_n), .hold(stall | flush), .clr(1'b0),
        .clr_val(32'h0), .d(pc_F), .q(pc_MW)
    );

    pipe_reg #(.W(1), .RST_VAL(1'b0)) u_valid_mw (
        .clk(clk), .rst_n(rst_n), .hold(stall), .clr(acc_flush),
        .clr_val(1'b0), .d(1'b1), .q(valid_MW)
    );

    // MW2 stage: bubbled by stall_MW, else follows MW
    pipe_reg #(.W(32), .RST_VAL(NOP_INST)) u_inst_mw2 (
        .clk(clk), .rst_n(rst_n), .hold(1'b0), .clr(stall_MW),
        .clr_val(NOP_INST), .d(inst_machine_codeMW),
        .q(inst_machine_codeMW2)
    );

    pipe_reg #(.W(32), .RST_VAL(32'h0)) u_alu_mw2 (
        .clk(clk), .rst_n(rst_n), .hold(1'b0), .clr(stall_MW),
        .clr_val(32'h0), .d(alu_res), .q(alu_resMW2)
    );

    pipe_reg #(.W(1), .RST_VAL(1'b0)) u_rw_mw2 (
        .clk(clk), .rst_n(rst_n), .hold(1'b0), .clr(stall_MW),
        .clr_val(1'b0), .d(reg_wr & valid_MW), .q(reg_wrMW2)
    );

    pipe_reg #(.W(1), .RST_VAL(1'b0)) u_valid_mw2 (
        .clk(clk), .rst_n(rst_n), .hold(1'b0), .clr(stall_MW),
        .clr_val(1'b0), .d(valid_MW), .q(valid_MW2)
    );

    // hazard FSM and sticky error: stalls must be single-cycle and paired
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            hz_err <= 1'b0;
        end else begin
            if ((state == ST_STALL && stall) || (stall != stall_MW)) begin
                hz_err <= 1'b1;
            end
            unique case (1'b1)
                stall:     state <= ST_STALL;
                acc_flush: state <= ST_FLUSH;
                default:   state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // wrapping performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt  <= 32'h0;
            flush_cnt  <= 32'h0;
            retire_cnt <= 32'h0;
        end else begin
            if (stall)     stall_cnt  <= stall_cnt + 32'd1;
            if (acc_flush) flush_cnt  <= flush_cnt + 32'd1;
            if (valid_MW2) retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_pipe_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, stall_MW, flush;
    logic [31:0] br_target, inst_F, alu_res;
    logic        reg_wr;
    logic [31:0] pc_F, inst_machine_codeMW, pc_MW;
    logic [31:0] inst_machine_codeMW2, alu_resMW2;
    logic        reg_wrMW2, valid_MW, valid_MW2;
    logic [1:0]  ctrl_state;
    logic        hz_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .stall_MW(stall_MW),
        .flush(flush), .br_target(br_target), .inst_F(inst_F),
        .alu_res(alu_res), .reg_wr(reg_wr), .pc_F(pc_F),
        .inst_machine_codeMW(inst_machine_codeMW), .pc_MW(pc_MW),
        .inst_machine_codeMW2(inst_machine_codeMW2),
        .alu_resMW2(alu_resMW2), .reg_wrMW2(reg_wrMW2),
        .valid_MW(valid_MW), .valid_MW2(valid_MW2),
        .ctrl_state(ctrl_state), .hz_err(hz_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .retire_cnt(retire_cnt)
`endif
    );

    // behavioural model: stages as records, state as a plain number
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu;
        bit          rw;
        bit          valid;
    } stage_t;

    logic [31:0] m_pc;
    stage_t      m_mw, m_mw2;
    int          m_state;
    bit          m_err;
    longint      m_stalls, m_flushes, m_retires;

    task automatic model_step(input bit r, input bit st, input bit smw,
                              input bit fl, input logic [31:0] br,
                              input logic [31:0] inst,
                              input logic [31:0] alu, input bit rw);
        stage_t nmw, nmw2;
        if (!r) begin
            m_pc = 32'h0;
            m_mw = '{inst: 32'h13, pc: 0, alu: 0, rw: 0, valid: 0};
            m_mw2 = '{inst: 32'h13, pc: 0, alu: 0, rw: 0, valid: 0};
            m_state = 0;
            m_err = 0;
            m_stalls = 0;
            m_flushes = 0;
            m_retires = 0;
        end else begin
            m_retires += m_mw2.valid ? 1 : 0;
            if (smw)
                nmw2 = '{inst: 32'h13, pc: 0, alu: 0, rw: 0, valid: 0};
            else
                nmw2 = '{inst: m_mw.inst, pc: 0, alu: alu,
                         rw: rw && m_mw.valid, valid: m_mw.valid};
            nmw = m_mw;
            if (st) begin
                m_stalls++;
            end else if (fl) begin
                m_flushes++;
                nmw.inst = 32'h13;
                nmw.valid = 0;
                m_pc = br;
            end else begin
                nmw.inst = inst;
                nmw.pc = m_pc;
                nmw.valid = 1;
                m_pc = m_pc + 32'd4;
            end
            if ((m_state == 1 && st) || (st != smw)) m_err = 1;
            m_state = st ? 1 : (fl ? 2 : 0);
            m_mw = nmw;
            m_mw2 = nmw2;
        end
    endtask

    task automatic apply(input bit r, input bit st, input bit smw,
                         input bit fl, input logic [31:0] br,
                         input logic [31:0] inst,
                         input logic [31:0] alu, input bit rw);
        rst_n = r;
        stall = st;
        stall_MW = smw;
        flush = fl;
        br_target = br;
        inst_F = inst;
        alu_res = alu;
        reg_wr = rw;
        model_step(r, st, smw, fl, br, inst, alu, rw);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " pc_F"}, pc_F, m_pc);
        chk({tag, " inst_MW"}, inst_machine_codeMW, m_mw.inst);
        chk({tag, " pc_MW"}, pc_MW, m_mw.pc);
        chk({tag, " valid_MW"}, {31'h0, valid_MW}, {31'h0, m_mw.valid});
        chk({tag, " inst_MW2"}, inst_machine_codeMW2, m_mw2.inst);
        chk({tag, " alu_MW2"}, alu_resMW2, m_mw2.alu);
        chk({tag, " rw_MW2"}, {31'h0, reg_wrMW2}, {31'h0, m_mw2.rw});
        chk({tag, " valid_MW2"}, {31'h0, valid_MW2}, {31'h0, m_mw2.valid});
        chk({tag, " state"}, {30'h0, ctrl_state}, m_state);
        chk({tag, " hz_err"}, {31'h0, hz_err}, {31'h0, m_err});
`ifdef PIPE_PERF_CNT_EN
        chk({tag, " stall_cnt"}, stall_cnt, m_stalls[31:0]);
        chk({tag, " flush_cnt"}, flush_cnt, m_flushes[31:0]);
        chk({tag, " retire_cnt"}, retire_cnt, m_retires[31:0]);
`endif
    endtask

    typedef struct {
        bit          st, smw, fl;
        logic [31:0] br, inst;
        logic [31:0] e_pc, e_inst, e_inst2;
        bit          e_v, e_rw2;
        logic [1:0]  e_state;
        bit          e_err;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{0, 0, 0, 32'h0, 32'h00500093,
                  32'h4, 32'h00500093, 32'h13, 1, 0, 2'd0, 0};
        vt[1] = '{1, 1, 0, 32'h0, 32'h00A00113,
                  32'h4, 32'h00500093, 32'h13, 1, 0, 2'd1, 0};
        vt[2] = '{0, 0, 0, 32'h0, 32'h00A00113,
                  32'h8, 32'h00A00113, 32'h00500093, 1, 1, 2'd0, 0};
        vt[3] = '{0, 0, 1, 32'h40, 32'hDEADBEEF,
                  32'h40, 32'h13, 32'h00A00113, 0, 1, 2'd2, 0};
        vt[4] = '{1, 1, 1, 32'h80, 32'hDEADBEEF,
                  32'h40, 32'h13, 32'h13, 0, 0, 2'd1, 0};
        vt[5] = '{0, 0, 0, 32'h0, 32'h00300193,
                  32'h44, 32'h00300193, 32'h13, 1, 0, 2'd0, 0};

        // reset state
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst pc_F", pc_F, 32'h0);
        chk("rst inst_MW", inst_machine_codeMW, 32'h13);
        chk("rst inst_MW2", inst_machine_codeMW2, 32'h13);
        chk("rst pc_MW", pc_MW, 32'h0);
        chk("rst alu_MW2", alu_resMW2, 32'h0);
        chk("rst flags", {26'h0, reg_wrMW2, valid_MW, valid_MW2,
                          hz_err, ctrl_state}, 32'h0);

        // vector table
        for (int i = 0; i < 6; i++) begin
            apply(1, vt[i].st, vt[i].smw, vt[i].fl, vt[i].br,
                  vt[i].inst, 32'h1000 + i, 1);
            chk($sformatf("vec%0d pc_F", i), pc_F, vt[i].e_pc);
            chk($sformatf("vec%0d inst_MW", i),
                inst_machine_codeMW, vt[i].e_inst);
            chk($sformatf("vec%0d valid_MW", i),
                {31'h0, valid_MW}, {31'h0, vt[i].e_v});
            chk($sformatf("vec%0d inst_MW2", i),
                inst_machine_codeMW2, vt[i].e_inst2);
            chk($sformatf("vec%0d rw_MW2", i),
                {31'h0, reg_wrMW2}, {31'h0, vt[i].e_rw2});
            chk($sformatf("vec%0d state", i),
                {30'h0, ctrl_state}, {30'h0, vt[i].e_state});
            chk($sformatf("vec%0d hz_err", i),
                {31'h0, hz_err}, {31'h0, vt[i].e_err});
        end
        check_all("vec_end");

        // two consecutive stalls -> sticky error
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 1, 0, 0, 32'h11, 0, 1);
        chk("stall1 hz_err", {31'h0, hz_err}, 32'h0);
        apply(1, 1, 1, 0, 0, 32'h11, 0, 1);
        chk("stall2 hz_err", {31'h0, hz_err}, 32'h1);
        apply(1, 0, 0, 0, 0, 32'h22, 0, 1);
        apply(1, 0, 0, 1, 32'h100, 32'h22, 0, 1);
        chk("sticky hz_err", {31'h0, hz_err}, 32'h1);
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        chk("clr hz_err", {31'h0, hz_err}, 32'h0);

        // unpaired stall -> error
        apply(1, 1, 0, 0, 0, 32'h33, 0, 1);
        chk("unpaired hz_err", {31'h0, hz_err}, 32'h1);

        // reset during stall leaves no residue
        apply(1, 1, 1, 0, 0, 32'h44, 0, 1);
        apply(0, 1, 1, 1, 32'h200, 32'h44, 0, 1);
        chk("rst_mid pc_F", pc_F, 32'h0);
        chk("rst_mid state", {30'h0, ctrl_state}, 32'h0);
        apply(1, 0, 0, 0, 0, 32'h55, 0, 1);
        chk("post_rst pc_F", pc_F, 32'h4);
        chk("post_rst hz_err", {31'h0, hz_err}, 32'h0);
        chk("post_rst state", {30'h0, ctrl_state}, 32'h0);

        // PC wrap
        apply(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h66, 0, 1);
        chk("wrap pre pc_F", pc_F, 32'hFFFF_FFFC);
        apply(1, 0, 0, 0, 0, 32'h77, 0, 1);
        chk("wrap pc_F", pc_F, 32'h0);
        chk("wrap pc_MW", pc_MW, 32'hFFFF_FFFC);
        chk("wrap hz_err", {31'h0, hz_err}, 32'h0);

`ifdef PIPE_PERF_CNT_EN
        // 3 stalls + 2 flushes
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 1, 0, 0, 1, 0, 1);
        apply(1, 0, 0, 0, 0, 1, 0, 1);
        apply(1, 1, 1, 0, 0, 1, 0, 1);
        apply(1, 0, 0, 0, 0, 1, 0, 1);
        apply(1, 1, 1, 0, 0, 1, 0, 1);
        apply(1, 0, 0, 1, 32'h40, 1, 0, 1);
        apply(1, 0, 0, 0, 0, 1, 0, 1);
        apply(1, 0, 0, 1, 32'h80, 1, 0, 1);
        chk("perf stall_cnt", stall_cnt, 32'd3);
        chk("perf flush_cnt", flush_cnt, 32'd2);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit r, st, smw, fl;
            r = ($urandom_range(0, 39) != 0);
            st = ($urandom_range(0, 3) == 0);
            smw = ($urandom_range(0, 15) == 0) ? !st : st;
            fl = ($urandom_range(0, 3) == 0);
            apply(r, st, smw, fl, $urandom & 32'hFFFF_FFFC, $urandom,
                  $urandom, $urandom_range(0, 1) == 1);
            check_all($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
